// File: rtl/note_lane_scroller.sv
// Falling-note grid for the rhythm game: scrolls rows on each go pulse, scores key hits, tracks misses.
// Optional macro WRONG_PRESS_PENALTY_EN: a press on an empty hit-row lane costs one point.
module note_lane_scroller #(
    parameter int LANES    = 4,
    parameter int ROWS     = 16,
    parameter int HIT_ROW  = 14,
    parameter int SCORE_W  = 8,
    parameter int MISS_MAX = 10
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          go,
    input  logic                          start,
    input  logic [LANES-1:0]              new_row,
    input  logic [LANES-1:0]              keys,
    input  logic [$clog2(ROWS)-1:0]       rd_row,
    output logic [LANES-1:0]              rd_data,
    output logic                          row_req,
    output logic                          hit,
    output logic                          miss,
    output logic [SCORE_W-1:0]            score,
    output logic [$clog2(MISS_MAX+1)-1:0] miss_count,
    output logic [1:0]                    state,
    output logic                          game_over
);

    localparam int MW        = $clog2(MISS_MAX + 1);
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } state_t;

    state_t                        st_q, st_d;
    logic [ROWS-1:0][LANES-1:0]    grid_q, grid_d, grid_h;
    logic [LANES-1:0]              keys_q, press, hits;
    logic [SCORE_W-1:0]            score_d;
    logic [MW-1:0]                 miss_d;
    logic                          hit_d, miss_p_d, row_req_d;
    int                            score_sum, miss_sum;

    function automatic int popcount(input logic [LANES-1:0] v);
        int n;
        n = 0;
        for (int unsigned i = 0; i < LANES; i++)
            if (v[i]) n++;
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            st_q       <= IDLE;
            grid_q     <= '0;
            keys_q     <= '0;
            score      <= '0;
            miss_count <= '0;
            rd_data    <= '0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            row_req    <= 1'b0;
        end else begin
            st_q       <= st_d;
            grid_q     <= grid_d;
            keys_q     <= keys;
            score      <= score_d;
            miss_count <= miss_d;
            rd_data    <= grid_q[rd_row];
            hit        <= hit_d;
            miss       <= miss_p_d;
            row_req    <= row_req_d;
        end
    end

    always_comb begin
        press     = keys & ~keys_q;
        hits      = press & grid_q[HIT_ROW];
        st_d      = st_q;
        grid_d    = grid_q;
        grid_h    = grid_q;
        score_d   = score;
        miss_d    = miss_count;
        hit_d     = 1'b0;
        miss_p_d  = 1'b0;
        row_req_d = 1'b0;
        score_sum = 0;
        miss_sum  = 0;
        case (st_q)
            IDLE, OVER: begin
                if (start) begin
                    st_d    = PLAY;
                    grid_d  = '0;
                    score_d = '0;
                    miss_d  = '0;
                end
            end
            PLAY: begin
                // Hit cells are cleared before the shift so a hit note can never also exit as a miss.
                grid_h[HIT_ROW] = grid_q[HIT_ROW] & ~press;
                score_sum = int'(score) + popcount(hits);
`ifdef WRONG_PRESS_PENALTY_EN
                score_sum = score_sum - popcount(press & ~grid_q[HIT_ROW]);
                if (score_sum < 0) score_sum = 0;
`endif
                if (score_sum > SCORE_MAX) score_sum = SCORE_MAX;
                score_d = SCORE_W'(score_sum);
                hit_d   = |hits;
                grid_d  = grid_h;
                if (go) begin
                    grid_d    = {grid_h[ROWS-2:0], new_row};
                    miss_sum  = int'(miss_count) + popcount(grid_h[ROWS-1]);
                    if (miss_sum > MISS_MAX) miss_sum = MISS_MAX;
                    miss_d    = MW'(miss_sum);
                    miss_p_d  = |grid_h[ROWS-1];
                    row_req_d = 1'b1;
                    if (miss_sum == MISS_MAX) st_d = OVER;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    assign state     = st_q;
    assign game_over = (st_q == OVER);

endmodule

// File: tb/tb_note_lane_scroller.sv
// Scoreboard bench for note_lane_scroller: a lane/row reference model predicts every cycle's outputs.
module tb_note_lane_scroller;
    localparam int LANES = 4, ROWS = 16, HIT_ROW = 14, SCORE_W = 8, MISS_MAX = 10;
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;

    logic       clk = 1'b0;
    logic       resetn, go, start;
    logic [3:0] new_row, keys, rd_row, rd_data;
    logic       row_req, hit, miss, game_over;
    logic [7:0] score;
    logic [3:0] miss_count;
    logic [1:0] state;

    note_lane_scroller #(
        .LANES(LANES), .ROWS(ROWS), .HIT_ROW(HIT_ROW), .SCORE_W(SCORE_W), .MISS_MAX(MISS_MAX)
    ) dut (
        .clk(clk), .resetn(resetn), .go(go), .start(start), .new_row(new_row), .keys(keys),
        .rd_row(rd_row), .rd_data(rd_data), .row_req(row_req), .hit(hit), .miss(miss),
        .score(score), .miss_count(miss_count), .state(state), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rd;
        logic       rr, h, m, ov;
        int         sc, mc, st;
    } exp_t;

    exp_t q[$];
    int   nchecks = 0;
    int   nerr = 0;

    // Reference model: grid as an array of lane masks, game state 0 idle / 1 play / 2 over.
    logic [3:0] m_grid [ROWS];
    int         m_state = 0, m_score = 0, m_miss = 0;
    logic [3:0] m_kprev = '0;

    function automatic int bits(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) if (v[i]) n++;
        return n;
    endfunction

    task automatic clear_grid();
        for (int r = 0; r < ROWS; r++) m_grid[r] = '0;
    endtask

    task automatic model_step();
        exp_t       e;
        logic [3:0] pr;
        int         nh, nw, pc;
        e.rd = m_grid[rd_row];
        e.rr = 0; e.h = 0; e.m = 0;
        if (!resetn) begin
            clear_grid();
            m_state = 0; m_score = 0; m_miss = 0; m_kprev = '0;
            e.rd = '0;
        end else begin
            pr = keys & ~m_kprev;
            if (m_state != 1) begin
                if (start) begin
                    m_state = 1; m_score = 0; m_miss = 0;
                    clear_grid();
                end
            end else begin
                nh = 0; nw = 0;
                for (int l = 0; l < LANES; l++) begin
                    if (pr[l]) begin
                        if (m_grid[HIT_ROW][l]) begin
                            nh++;
                            m_grid[HIT_ROW][l] = 1'b0;
                        end else nw++;
                    end
                end
`ifndef WRONG_PRESS_PENALTY_EN
                nw = 0;
`endif
                m_score = m_score + nh - nw;
                if (m_score < 0) m_score = 0;
                if (m_score > SCORE_MAX) m_score = SCORE_MAX;
                e.h = (nh > 0);
                if (go) begin
                    pc = bits(m_grid[ROWS-1]);
                    e.m = (pc > 0);
                    e.rr = 1;
                    m_miss = (m_miss + pc > MISS_MAX) ? MISS_MAX : m_miss + pc;
                    for (int r = ROWS - 1; r > 0; r--) m_grid[r] = m_grid[r-1];
                    m_grid[0] = new_row;
                    if (m_miss == MISS_MAX) m_state = 2;
                end
            end
            m_kprev = keys;
        end
        e.sc = m_score; e.mc = m_miss; e.st = m_state; e.ov = (m_state == 2);
        q.push_back(e);
    endtask

    task automatic drive(input logic rn, input logic g, input logic s,
                         input logic [3:0] nr, input logic [3:0] k, input logic [3:0] rr);
        @(negedge clk);
        resetn = rn; go = g; start = s; new_row = nr; keys = k; rd_row = rr;
        model_step();
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd_data", rd_data, e.rd);
                chk("row_req", row_req, e.rr);
                chk("hit", hit, e.h);
                chk("miss", miss, e.m);
                chk("score", score, e.sc);
                chk("miss_count", miss_count, e.mc);
                chk("state", state, e.st);
                chk("game_over", game_over, e.ov);
            end
        end
    end

    initial begin : stim
        logic [3:0] k;
        resetn = 0; go = 0; start = 0; new_row = '0; keys = '0; rd_row = '0;
        clear_grid();
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);                       // go ignored in IDLE
        drive(1, 0, 1, 0, 0, 0);                       // start
        drive(1, 1, 0, 4'b0001, 0, 0);
        drive(1, 0, 0, 0, 0, 0);                       // read back row 0
        drive(1, 1, 0, 4'b0010, 0, 0);
        repeat (14) drive(1, 1, 0, 0, 0, 4'(HIT_ROW));
        drive(1, 0, 0, 0, 4'b0010, 4'(HIT_ROW));       // hit on lane 1
        drive(1, 0, 0, 0, 0, 4'(HIT_ROW));
        drive(1, 1, 0, 4'b0100, 0, 0);                 // unpressed note
        repeat (16) drive(1, 1, 0, 0, 0, 4'(ROWS - 1));
        repeat (10) drive(1, 1, 0, 4'b1111, 0, 0);
        repeat (20) drive(1, 1, 0, 0, 4'b0101, 0);     // exits until OVER
        repeat (5) drive(1, 1, 0, 4'b1111, 4'b1010, 0);
        drive(1, 0, 1, 0, 0, 0);                       // restart from OVER
        drive(1, 1, 0, 4'b1000, 0, 0);
        repeat (13) drive(1, 1, 0, 0, 0, 4'(HIT_ROW));
        repeat (5) drive(1, 1, 0, 0, 4'b1000, 4'(HIT_ROW)); // go + press, then held
        repeat (4) drive(1, 1, 0, 0, 0, 4'(ROWS - 1));
        for (int i = 0; i < 80; i++) begin            // drive score to saturation
            drive(1, 1, 0, 4'b1111, 0, 0);
            drive(1, 0, 0, 0, 4'b1111, 4'(HIT_ROW));
            drive(1, 0, 0, 0, 0, 4'(HIT_ROW));
        end
        drive(1, 1, 1, 0, 0, 0);                       // start ignored in PLAY
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0);
        drive(1, 1, 0, 4'b0001, 0, 0);
        repeat (14) drive(1, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 4'b0001, 4'(HIT_ROW));       // score 1
        drive(1, 0, 0, 0, 4'b1001, 0);                 // wrong press
        drive(1, 0, 0, 0, 4'b0001, 0);
        drive(1, 0, 0, 0, 4'b1001, 0);                 // second wrong press
        drive(1, 0, 0, 0, 0, 0);
        k = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 1)
                k = m_grid[HIT_ROW] | 4'($urandom & $urandom & $urandom);
            else
                k = k ^ 4'($urandom & $urandom);
            drive(($urandom_range(0, 399) != 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 39) == 0), 4'($urandom & $urandom), k, 4'($urandom));
        end
        repeat (2) @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
